// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEFAULT       = 18;
  localparam int unsigned DEFAULT_DIV_DEFAULT = 250000;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_width(input int unsigned n);
    int unsigned w;
    w = int'($clog2(n));
    return (n <= 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: active/shadow half-period, counter, tick and divided clock.
module clock_divider_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic             cfg_sync,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             pending,
  output logic             tick,
  output logic             slow_clk
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic             div_zero;
  logic             wrap;

  assign div_zero = (div == '0);
  assign wrap     = en && !div_zero && (cnt == div - CNT_W'(1));

  // Counting first, then any accepted update overrides (sync beats a wrap).
  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= CNT_W'(DEFAULT_DIV);
      shadow   <= CNT_W'(DEFAULT_DIV);
      cnt      <= '0;
      pending  <= 1'b0;
      tick     <= 1'b0;
      slow_clk <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (pending && (!en || div_zero)) begin
        div     <= shadow;
        cnt     <= '0;
        pending <= 1'b0;
      end else if (wrap) begin
        cnt      <= '0;
        tick     <= 1'b1;
        slow_clk <= ~slow_clk;
        if (pending) begin
          div     <= shadow;
          pending <= 1'b0;
        end
      end else if (en && !div_zero) begin
        cnt <= cnt + CNT_W'(1);
      end else if (div_zero) begin
        cnt <= '0;
      end

      if (cfg_wr) begin
        if (cfg_sync) begin
          div      <= cfg_div;
          cnt      <= '0;
          slow_clk <= 1'b0;
          tick     <= 1'b0;
          pending  <= 1'b0;
        end else begin
          shadow  <= cfg_div;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// Bank of independent clock dividers sharing one valid/ready divisor update port.
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]            cfg_div,
  input  logic                        cfg_sync,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           slow_clk
);

  localparam int unsigned CH_W    = ch_width(NUM_CH);
  localparam int unsigned CH_SPAN = 1 << CH_W;

  logic [NUM_CH-1:0]  pending;
  logic [CH_SPAN-1:0] pending_span;
  logic               cfg_xfer;

  // Unused select codes map to zero-padded bits, so they always read ready.
  assign pending_span = CH_SPAN'(pending);
  assign cfg_ready    = ~pending_span[cfg_ch];
  assign cfg_xfer     = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_wr;
    assign cfg_wr = cfg_xfer && (cfg_ch == CH_W'(i));

    clock_divider_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .cfg_wr   (cfg_wr),
      .cfg_sync (cfg_sync),
      .cfg_div  (cfg_div),
      .pending  (pending[i]),
      .tick     (tick[i]),
      .slow_clk (slow_clk[i])
    );
  end

endmodule
